posit_accum_prod_round_16: RTL and testbench

- Downstream of the raw accumulator `positaccum_accumprod_16_raw`; consumes its `result`/`done`/`truncated` outputs.
- Converts the wide raw accumulated value (sgn, scale, fraction, inf, zero) into a 16-bit, es=2 posit.
- Rounding is round-to-nearest-even, with saturation to maxpos/minpos.
- Fully pipelined: one conversion accepted per clock, fixed latency.

---
 rtl/posit_accum_prod_round_16_pkg.sv | 58 +++++
 rtl/posit_accum_prod_round_16_shift_right.sv | 31 +++
 rtl/posit_accum_prod_round_16.sv | 233 +++++++++++++++++++++++
 tb/tb_posit_accum_prod_round_16.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/posit_accum_prod_round_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_accum_prod_round_16_pkg
// Description : Shared definitions for the 16-bit, es=2 posit rounding stage
//               that sits behind the raw product accumulator. Holds the
//               serialized raw-value layout, the scale saturation bounds and
//               the value_accum_prod record used to capture the raw input.
// Contents    : field index constants, scale bounds, shifter geometry,
//               value_accum_prod typedef, unpack_value() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_accum_prod_round_16_pkg;

    // Serialized raw accumulator value: {sgn, scale[8:0], fraction[146:0], inf, zero}
    localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2 = 159;

    localparam int SGN_BIT   = 158;
    localparam int SCALE_MSB = 157;
    localparam int SCALE_LSB = 149;
    localparam int FRAC_MSB  = 148;
    localparam int FRAC_LSB  = 2;
    localparam int INF_BIT   = 1;
    localparam int ZERO_BIT  = 0;

    localparam int SCALE_W = SCALE_MSB - SCALE_LSB + 1;   // 9
    localparam int FRAC_W  = FRAC_MSB - FRAC_LSB + 1;     // 147

    // Largest / smallest scale representable by a 16-bit es=2 posit
    localparam int POSIT16_ES2_MAXSCALE = 56;
    localparam int POSIT16_ES2_MINSCALE = -56;

    // Alignment shifter geometry: {e, fraction, pad} shifted right by the
    // regime length (at most 16, so 6 shift bits are enough).
    localparam int SHIFT_N = 152;
    localparam int SHIFT_S = 6;

    typedef struct packed {
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]         fraction;
        logic                      inf;
        logic                      zero;
    } value_accum_prod;

    function automatic value_accum_prod unpack_value(
        input logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] raw
    );
        value_accum_prod v;
        v.sgn      = raw[SGN_BIT];
        v.scale    = raw[SCALE_MSB:SCALE_LSB];
        v.fraction = raw[FRAC_MSB:FRAC_LSB];
        v.inf      = raw[INF_BIT];
        v.zero     = raw[ZERO_BIT];
        return v;
    endfunction

endpackage : posit_accum_prod_round_16_pkg
`default_nettype wire

// File: rtl/posit_accum_prod_round_16_shift_right.sv
`default_nettype none
// ============================================================================
// Module      : shift_right
// Description : Combinational logarithmic right shifter (zero fill).
// Ports       : i_data  [N-1:0] value to shift
//               i_shamt [S-1:0] shift amount
//               o_data  [N-1:0] i_data >> i_shamt
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right #(
    parameter int N = 152,
    parameter int S = 6
) (
    input  logic [N-1:0] i_data,
    input  logic [S-1:0] i_shamt,
    output logic [N-1:0] o_data
);

    logic [N-1:0] w_stage [0:S];

    assign w_stage[0] = i_data;

    // Stage i shifts by 2**i when bit i of the amount is set
    for (genvar i = 0; i < S; i++) begin : g_stage
        assign w_stage[i+1] = i_shamt[i] ? (w_stage[i] >> (2**i)) : w_stage[i];
    end

    assign o_data = w_stage[S];

endmodule : shift_right
`default_nettype wire

// File: rtl/posit_accum_prod_round_16.sv
`default_nettype none
// ============================================================================
// Module      : posit_accum_prod_round_16
// Description : Converts the raw accumulated value (sgn, scale, fraction,
//               inf, zero) into a 16-bit es=2 posit with round-to-nearest-
//               even and saturation to maxpos/minpos. Three-stage pipeline,
//               one conversion per clock, fixed latency.
// Ports       : clk          system clock, rising edge
//               rst          asynchronous active-high reset
//               in1          raw value {sgn, scale, fraction, inf, zero}
//               start        in1/truncated_in valid this cycle
//               truncated_in accumulator dropped low bits (sticky)
//               result       rounded posit, held between conversions
//               done         one-cycle pulse, result valid
//               inexact      result differs from the exact input
// Revision    : 1.0 - initial release
// ============================================================================
import posit_accum_prod_round_16_pkg::*;

module posit_accum_prod_round_16 #(
    parameter int NBITS = 16,
    parameter int ES    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] in1,
    input  logic                                             start,
    input  logic                                             truncated_in,
    output logic [NBITS-1:0]                                 result,
    output logic                                             done,
    output logic                                             inexact
);

    localparam int MAG_W = NBITS - 1;

    // {e, fraction} is padded with zeros at the bottom to fill the shifter
    localparam int c_pad_w    = SHIFT_N - ES - FRAC_W;
    // Top NBITS bits of the shifted vector form the regime/e/fraction window:
    // MAG_W magnitude bits followed by the guard bit.
    localparam int c_win_lsb  = SHIFT_N - NBITS;
    // Fraction bits below this index can never reach the window, even at the
    // shortest regime; they may be shifted off the bottom, so they are ORed
    // into sticky directly.
    localparam int c_lost_w   = NBITS - c_pad_w;

    localparam logic signed [SCALE_W-1:0] c_max_scale = SCALE_W'(POSIT16_ES2_MAXSCALE);
    localparam logic signed [SCALE_W-1:0] c_min_scale = SCALE_W'(POSIT16_ES2_MINSCALE);

    localparam logic [NBITS-1:0] c_win_ones   = '1;
    localparam logic [NBITS-1:0] c_win_msb    = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [MAG_W-1:0] c_maxpos_mag = '1;
    localparam logic [MAG_W-1:0] c_minpos_mag = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic [NBITS-1:0] c_nar        = {1'b1, {(NBITS-1){1'b0}}};

    // ------------------------------------------------------------------------
    // S1: capture input
    // ------------------------------------------------------------------------
    logic            r_s1_valid;
    value_accum_prod r_s1_val;
    logic            r_s1_trunc;

    // An unknown start must not launch a conversion
    logic w_start_known;
    assign w_start_known = (start === 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_trunc <= 1'b0;
        end else begin
            r_s1_valid <= w_start_known;
            if (w_start_known) begin
                r_s1_val   <= unpack_value(in1);
                r_s1_trunc <= truncated_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2: regime / exponent / fraction window
    // ------------------------------------------------------------------------
    logic signed [SCALE_W-1:0] w_scale;
    logic signed [SCALE_W-1:0] w_k;
    logic                      w_k_neg;
    logic [4:0]                w_k_mag;
    logic [SHIFT_S-1:0]        w_rlen;
    logic [NBITS-1:0]          w_regime;
    logic [ES-1:0]             w_e;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [SHIFT_N-1:0]        w_shift_in;
    logic [SHIFT_N-1:0]        w_shifted;
    logic [NBITS-1:0]          w_window;
    logic                      w_sticky;

    assign w_scale  = r_s1_val.scale;
    assign w_sat_hi = (w_scale > c_max_scale);
    assign w_sat_lo = (w_scale < c_min_scale);
    assign w_k      = w_scale >>> ES;
    assign w_e      = w_scale[ES-1:0];
    assign w_k_neg  = w_k[SCALE_W-1];

    // |k| fits in 5 bits whenever the value is not saturated; the saturated
    // cases override the window, so truncation there is harmless.
    assign w_k_mag  = w_k_neg ? 5'(-w_k) : 5'(w_k);

    // Regime length including its terminator: k+2 ones/zero or |k|+1 zeros/one
    assign w_rlen   = w_k_neg ? (SHIFT_S'(w_k_mag) + SHIFT_S'(1))
                              : (SHIFT_S'(w_k_mag) + SHIFT_S'(2));

    // k>=0: k+1 leading ones (terminating zero implicit)
    // k<0 : |k| leading zeros then a one
    assign w_regime = w_k_neg ? (c_win_msb >> w_k_mag)
                              : ~(c_win_ones >> (w_k_mag + 5'd1));

    assign w_shift_in = {w_e, r_s1_val.fraction, {c_pad_w{1'b0}}};

    shift_right #(
        .N (SHIFT_N),
        .S (SHIFT_S)
    ) u_shift_right (
        .i_data  (w_shift_in),
        .i_shamt (w_rlen),
        .o_data  (w_shifted)
    );

    // Shifted e/fraction leave the top w_rlen bits clear for the regime
    assign w_window = w_shifted[SHIFT_N-1:c_win_lsb] | w_regime;
    assign w_sticky = (|w_shifted[c_win_lsb-1:0])
                    | (|r_s1_val.fraction[c_lost_w-1:0])
                    | r_s1_trunc;

    logic             r_s2_valid;
    logic             r_s2_sgn;
    logic             r_s2_inf;
    logic             r_s2_zero;
    logic             r_s2_sat_hi;
    logic             r_s2_sat_lo;
    logic [NBITS-1:0] r_s2_window;
    logic             r_s2_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sgn    <= 1'b0;
            r_s2_inf    <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_sat_hi <= 1'b0;
            r_s2_sat_lo <= 1'b0;
            r_s2_window <= '0;
            r_s2_sticky <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sgn    <= r_s1_val.sgn;
                r_s2_inf    <= r_s1_val.inf;
                r_s2_zero   <= r_s1_val.zero;
                r_s2_sat_hi <= w_sat_hi;
                r_s2_sat_lo <= w_sat_lo;
                r_s2_window <= w_window;
                r_s2_sticky <= w_sticky;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S3: round, saturate, negate, drive outputs
    // ------------------------------------------------------------------------
    logic [MAG_W-1:0] w_mag_trunc;
    logic             w_guard;
    logic             w_round_up;
    logic [MAG_W-1:0] w_mag_rnd;
    logic [MAG_W-1:0] w_mag;
    logic [NBITS-1:0] w_signed;
    logic [NBITS-1:0] w_result;
    logic             w_inexact;

    assign w_mag_trunc = r_s2_window[NBITS-1:1];
    assign w_guard     = r_s2_window[0];

    // RNE; maxpos never increments so the carry cannot reach the sign bit
    assign w_round_up  = w_guard & (r_s2_sticky | w_mag_trunc[0])
                       & (w_mag_trunc != c_maxpos_mag);
    assign w_mag_rnd   = w_mag_trunc + MAG_W'(w_round_up);

    always_comb begin
        w_mag = w_mag_rnd;
        if (r_s2_sat_hi) begin
            w_mag = c_maxpos_mag;
        end else if (r_s2_sat_lo || (w_mag_rnd == '0)) begin
            w_mag = c_minpos_mag;
        end
    end

    assign w_signed = r_s2_sgn ? (~{1'b0, w_mag} + NBITS'(1)) : {1'b0, w_mag};

    always_comb begin
        w_result  = w_signed;
        w_inexact = w_guard | r_s2_sticky | r_s2_sat_hi | r_s2_sat_lo;
        if (r_s2_inf) begin
            w_result  = c_nar;
            w_inexact = 1'b0;
        end else if (r_s2_zero) begin
            w_result  = '0;
            w_inexact = 1'b0;
        end
    end

    logic [NBITS-1:0] r_result;
    logic             r_done;
    logic             r_inexact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_done    <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            r_done <= r_s2_valid;
            if (r_s2_valid) begin
                r_result  <= w_result;
                r_inexact <= w_inexact;
            end
        end
    end

    assign result  = r_result;
    assign done    = r_done;
    assign inexact = r_inexact;

endmodule : posit_accum_prod_round_16
`default_nettype wire

// File: tb/tb_posit_accum_prod_round_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_accum_prod_round_16
// Description : Scoreboard bench for posit_accum_prod_round_16. The driver
//               pushes hand-computed expected posits into queues; a monitor
//               pops and compares on every done pulse, including the cycle
//               on which done is expected.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_posit_accum_prod_round_16;
    import posit_accum_prod_round_16_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [158:0] in1;
    logic         start;
    logic         truncated_in;
    logic [15:0]  result;
    logic         done;
    logic         inexact;

    always #5 clk = ~clk;

    posit_accum_prod_round_16 #(
        .NBITS (16),
        .ES    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in1          (in1),
        .start        (start),
        .truncated_in (truncated_in),
        .result       (result),
        .done         (done),
        .inexact      (inexact)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] q_res  [$];
    logic        q_inx  [$];
    int          q_cyc  [$];
    string       q_name [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q_res.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                automatic logic [15:0] er = q_res.pop_front();
                automatic logic        ei = q_inx.pop_front();
                automatic int          ec = q_cyc.pop_front();
                automatic string       nm = q_name.pop_front();
                check({nm, " result"},  {16'b0, result},  {16'b0, er});
                check({nm, " inexact"}, {31'b0, inexact}, {31'b0, ei});
                check({nm, " latency"}, cyc, ec);
            end
        end
    end

    task automatic send(input string name, input logic s, input int sc,
                        input logic [146:0] f, input logic inf, input logic zero,
                        input logic tr, input logic [15:0] er, input logic ei);
        @(negedge clk);
        in1          = {s, 9'(sc), f, inf, zero};
        truncated_in = tr;
        start        = 1'b1;
        q_res.push_back(er);
        q_inx.push_back(ei);
        q_cyc.push_back(cyc + 3);
        q_name.push_back(name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start        = 1'b0;
            truncated_in = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q_res.size() != 0; i++) @(negedge clk);
        #1;
        check("drain outstanding", q_res.size(), 32'd0);
        q_res.delete(); q_inx.delete(); q_cyc.delete(); q_name.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [146:0] f0, fmsb, ftie, fones;

    initial begin
        f0    = '0;
        fmsb  = '0; fmsb[146] = 1'b1;
        ftie  = '0; ftie[135] = 1'b1;
        fones = '1;

        rst = 1'b1; start = 1'b0; in1 = '0; truncated_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset result",  {16'b0, result},  32'd0);
        check("reset done",    {31'b0, done},    32'd0);
        check("reset inexact", {31'b0, inexact}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Single isolated conversion
        send("one", 0, 0, f0, 0, 0, 0, 16'h4000, 0);
        idle(3);

        // Back-to-back stream (start held for many cycles)
        send("1p5",         0,   0, fmsb,  0, 0, 0, 16'h4400, 0);
        send("m1p5",        1,   0, fmsb,  0, 0, 0, 16'hBC00, 0);
        send("tie_even",    0,   0, ftie,  0, 0, 0, 16'h4000, 1);
        send("tie_sticky",  0,   0, ftie,  0, 0, 1, 16'h4001, 1);
        send("round_carry", 0,   0, fones, 0, 0, 0, 16'h4800, 1);
        send("sat_hi",      0,  60, f0,    0, 0, 0, 16'h7FFF, 1);
        send("sat_lo",      0, -60, f0,    0, 0, 0, 16'h0001, 1);
        send("sat_lo_neg",  1, -60, f0,    0, 0, 0, 16'hFFFF, 1);
        send("maxscale",    0,  56, f0,    0, 0, 0, 16'h7FFF, 0);
        send("minscale",    0, -56, f0,    0, 0, 0, 16'h0001, 0);
        send("zero",        0,   0, f0,    0, 1, 0, 16'h0000, 0);
        send("nar",         0,   0, f0,    1, 1, 1, 16'h8000, 0);
        send("scale5",      0,   5, f0,    0, 0, 0, 16'h6400, 0);
        send("scale5_neg",  1,   5, f0,    0, 0, 0, 16'h9C00, 0);
        send("scale_m1",    0,  -1, f0,    0, 0, 0, 16'h3800, 0);
        idle(1);
        drain();

        // Reset with two conversions in flight: both are discarded
        send("inflight_a", 0, 5, f0,   0, 0, 0, 16'h6400, 0);
        send("inflight_b", 0, 0, fmsb, 0, 0, 0, 16'h4400, 0);
        @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b1;
        q_res.delete(); q_inx.delete(); q_cyc.delete(); q_name.delete();
        #1;
        check("midrst done",    {31'b0, done},    32'd0);
        check("midrst result",  {16'b0, result},  32'd0);
        check("midrst inexact", {31'b0, inexact}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);
        check("post_rst result", {16'b0, result}, 32'd0);

        send("after_reset", 0, 0, fmsb, 0, 0, 0, 16'h4400, 0);
        idle(1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_posit_accum_prod_round_16
`default_nettype wire
